ysyx_22051013_mem_arbiter: RTL and testbench
============================================

# ysyx_22051013_mem_arbiter

Two-master, single-slave memory-port arbiter that shares the one external memory/AXI-bridge port between the instruction cache miss path and the data cache miss/writeback path. It sits between the i-cache/d-cache refill interfaces and the AXI bridge. It grants one outstanding transaction at a time, registers the request, and returns a one-cycle response pulse to the owning cache.

## Interface
Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, data beat width
- STRB_W, 8, write byte-strobe width (DATA_W/8)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- i_ena  in  1  i-cache read request; held until i_valid
- i_addr  in  ADDR_W  i-cache read address, 8-byte aligned
- i_data  out  DATA_W  read data to i-cache
- i_valid  out  1  one-cycle completion pulse to i-cache
- d_ena  in  1  d-cache request; held until d_valid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  d-cache address
- d_wdata  in  DATA_W  write data
- d_wstrb  in  STRB_W  write byte enables
- d_data  out  DATA_W  read data to d-cache
- d_valid  out  1  one-cycle completion pulse to d-cache
- m_req  out  1  request to bridge
- m_we  out  1  write flag to bridge
- m_addr  out  ADDR_W  address to bridge
- m_wdata  out  DATA_W  write data to bridge
- m_wstrb  out  STRB_W  strobes to bridge
- m_ack  in  1  bridge accepted request (m_req & m_ack = handshake)
- m_done  in  1  bridge completion pulse (read data or write response)
- m_rdata  in  DATA_W  read data, valid with m_done

## Operation
- States: IDLE, ISSUE, WAIT, RESP. The owner register (I or D) is loaded on grant.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If one or both requests are pending, pick a winner per the arbitration policy.
  - Latch the winner's addr/we/wdata/wstrb into the request registers. For the i-cache owner, we=0 and wstrb=0.
  - Go to ISSUE.
- ISSUE:
  - m_req=1, driven from the registers.
  - On m_ack, go to WAIT. m_req drops the next cycle.
- WAIT:
  - On m_done, capture m_rdata into the response register and go to RESP.
  - m_done arriving in the same cycle as m_ack (ISSUE state) goes directly to RESP.
- RESP:
  - Pulse the owner's valid for exactly one cycle, with data from the response register.
  - The non-owner valid stays 0.
  - Go to IDLE.
- A request arriving while another transaction is in flight waits. It is never dropped; the requester holds ena.
- A requester's ena is ignored in the IDLE cycle immediately after its own RESP. This is the one-cycle re-arm gap.
- i_data/d_data are valid only during the respective valid pulse; they read 0 otherwise.
- Write responses: d_valid pulses and d_data=0.
- The arbiter never issues a second transaction before the current one reaches RESP.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, owner=I, all outputs 0, request/response registers 0, round-robin pointer points at the i-cache.
- Minimum latency from ena to valid, when m_ack is asserted in the first ISSUE cycle and m_done arrives one cycle later:
  - cycle 0 IDLE grant, cycle 1 ISSUE/ack, cycle 2 WAIT/done, cycle 3 RESP valid.
  - Total 3 cycles plus bridge latency.
- The m_* outputs are stable while m_req=1 until m_ack.
- Reset asserted mid-transaction aborts immediately to IDLE with all outputs 0. The bridge is reset on the same net.
- m_done in IDLE or RESP is ignored.

## Configuration
- YSYX_22051013_ARB_RR_EN defined: round-robin arbitration.
  - A one-bit pointer flips to the other master after each grant that was contested, so it favours the loser of the last contest.
  - Uncontested grants leave the pointer unchanged.
- Undefined: fixed priority, d-cache wins every tie.
- The pointer register is not present when the macro is undefined.

## Test plan
- Single i-cache read: i_ena=1, i_addr=0x8000_0008; bridge acks immediately and gives m_done after 2 cycles with m_rdata=0x1111_2222_3333_4444 -> m_addr=0x8000_0008, m_we=0, then one i_valid pulse with i_data=0x1111_2222_3333_4444; d_valid stays 0.
- d-cache write: d_ena=1, d_we=1, d_addr=0x8000_1000, d_wdata=0xDEAD_BEEF_0000_0001, d_wstrb=0x0F -> m_we=1 with matching wdata/wstrb; one d_valid pulse with d_data=0.
- Simultaneous requests, both held for 3 transactions:
  - Without ARB_RR_EN, the grant order is D, D, D.
  - With ARB_RR_EN (pointer at I after reset), the grant order is I, D, I.
- Back-pressure: m_ack held low for 5 cycles -> m_req and m_addr stay constant for 5 cycles; no valid is produced; the other master's ena is not granted.
- m_done in the same cycle as m_ack -> RESP on the next cycle; valid exactly 1 cycle wide.
- rst pulled low during WAIT -> all outputs 0 immediately (asynchronously); after release, a fresh i_ena request completes normally.

Source files
------------

// File: rtl/ysyx_22051013_mem_arbiter.sv
// ysyx_22051013_mem_arbiter
// Shares the single bridge port between the i-cache refill path and the
// d-cache refill/writeback path. It handles one transaction at a time.
// Each completed transaction produces a one-cycle valid pulse to the
// cache that owns it.
//
// Optional feature macro: YSYX_22051013_ARB_RR_EN
//   defined   : round-robin on contested grants; the pointer favours the
//               master that lost the previous contest
//   undefined : fixed priority, the d-cache wins every tie
//
// States (r_state)
//   state | meaning
//   IDLE  | no transaction; arbitrate and latch the winner's request
//   ISSUE | m_req high from the request registers until m_ack
//   WAIT  | request accepted; waiting for m_done
//   RESP  | owner's valid pulse with the captured response
module ysyx_22051013_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ena,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_valid,
  input  logic              d_ena,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic [DATA_W-1:0] d_data,
  output logic              d_valid,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_ack,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // owner encoding: 0 = i-cache, 1 = d-cache
  state_t            r_state;
  logic              r_owner;
  logic              r_gap;
  logic              r_m_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0] r_resp;
  logic              r_i_valid;
  logic              r_d_valid;

  logic w_any;
  logic w_contest;
  logic w_pick_d;
  logic w_grant;

  assign w_any     = i_ena | d_ena;
  assign w_contest = i_ena & d_ena;
  // The IDLE cycle right after a response never grants. A requester that
  // holds ena is then arbitrated afresh on the following cycle.
  assign w_grant   = (r_state == S_IDLE) && !r_gap && w_any;

`ifdef YSYX_22051013_ARB_RR_EN
  logic r_ptr;

  assign w_pick_d = w_contest ? r_ptr : d_ena;

  // Round-robin pointer: after a contested grant it points at the loser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else if (w_grant && w_contest) begin
      r_ptr <= ~w_pick_d;
    end
  end
`else
  assign w_pick_d = d_ena;
`endif

  // Main transaction FSM with registered bridge and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_gap     <= 1'b0;
      r_m_req   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_resp    <= '0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
    end else begin
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_gap <= 1'b0;
          if (w_grant) begin
            r_owner <= w_pick_d;
            r_addr  <= w_pick_d ? d_addr : i_addr;
            r_we    <= w_pick_d & d_we;
            r_wdata <= w_pick_d ? d_wdata : '0;
            r_wstrb <= w_pick_d ? d_wstrb : '0;
            r_m_req <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_ack) begin
            r_m_req <= 1'b0;
            if (m_done) begin
              r_resp    <= r_we ? '0 : m_rdata;
              r_i_valid <= ~r_owner;
              r_d_valid <= r_owner;
              r_state   <= S_RESP;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (m_done) begin
            r_resp    <= r_we ? '0 : m_rdata;
            r_i_valid <= ~r_owner;
            r_d_valid <= r_owner;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          r_resp  <= '0;
          r_gap   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_we;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign m_wstrb = r_wstrb;
  assign i_valid = r_i_valid;
  assign d_valid = r_d_valid;
  assign i_data  = {DATA_W{r_i_valid}} & r_resp;
  assign d_data  = {DATA_W{r_d_valid}} & r_resp;

endmodule

// File: tb/tb_ysyx_22051013_mem_arbiter.sv
// Testbench for ysyx_22051013_mem_arbiter: directed stimulus with a bridge
// driver, and a scoreboard monitor checking every response pulse.
module tb_ysyx_22051013_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ena;
  logic [63:0] i_addr;
  logic [63:0] i_data;
  logic        i_valid;
  logic        d_ena;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_wstrb;
  logic [63:0] d_data;
  logic        d_valid;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_ack;
  logic        m_done;
  logic [63:0] m_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        own_d;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  ysyx_22051013_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STRB_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_ena(i_ena), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid),
    .d_ena(d_ena), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_data(d_data), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ack(m_ack), .m_done(m_done), .m_rdata(m_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every valid pulse pops one expected response.
  always @(negedge clk) begin
    if (rst) begin
      chk("valid_exclusive", {63'b0, i_valid & d_valid}, 64'd0);
      if (!i_valid) chk("i_data_idle", i_data, 64'd0);
      if (!d_valid) chk("d_data_idle", d_data, 64'd0);
      if (i_valid || d_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: i_valid=%b d_valid=%b, none expected at %0t",
                   i_valid, d_valid, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_owner", {63'b0, d_valid}, {63'b0, mon_e.own_d});
          chk("resp_data", d_valid ? d_data : i_data, mon_e.data);
        end
      end
    end
  end

  task automatic check_zero();
    chk("zero_ctl", {60'b0, m_req, m_we, i_valid, d_valid}, 64'd0);
    chk("zero_m_addr", m_addr, 64'd0);
    chk("zero_m_wdata", m_wdata, 64'd0);
    chk("zero_m_wstrb", {56'b0, m_wstrb}, 64'd0);
    chk("zero_i_data", i_data, 64'd0);
    chk("zero_d_data", d_data, 64'd0);
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20; k++) begin
      if (m_req) break;
      @(negedge clk);
    end
    chk("m_req_seen", {63'b0, m_req}, 64'd1);
  endtask

  // Bridge model: checks the presented request, stalls ack, then completes.
  task automatic serve(input logic [63:0] e_addr, input logic e_we,
                       input logic [63:0] e_wdata, input logic [7:0] e_wstrb,
                       input int ack_delay, input int done_delay,
                       input logic [63:0] rdata, input bit same_cycle);
    wait_req();
    chk("m_addr", m_addr, e_addr);
    chk("m_we", {63'b0, m_we}, {63'b0, e_we});
    chk("m_wdata", m_wdata, e_wdata);
    chk("m_wstrb", {56'b0, m_wstrb}, {56'b0, e_wstrb});
    for (int k = 0; k < ack_delay; k++) begin
      @(negedge clk);
      chk("bp_m_req", {63'b0, m_req}, 64'd1);
      chk("bp_m_addr", m_addr, e_addr);
    end
    m_ack   = 1'b1;
    m_done  = same_cycle;
    m_rdata = rdata;
    @(negedge clk);
    m_ack  = 1'b0;
    m_done = 1'b0;
    if (!same_cycle) begin
      for (int k = 1; k < done_delay; k++) @(negedge clk);
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
    end
  endtask

  task automatic wait_valid(input bit want_d);
    for (int k = 0; k < 10; k++) begin
      if (want_d ? d_valid : i_valid) break;
      @(negedge clk);
    end
    chk("valid_seen", {63'b0, (want_d ? d_valid : i_valid)}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  order;
    logic        own;
    logic [63:0] rd;

    rst = 1'b0;
    i_ena = 1'b0; i_addr = '0;
    d_ena = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    m_ack = 1'b0; m_done = 1'b0; m_rdata = '0;
    #2;
    check_zero();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero();

    // single i-cache read
    i_ena = 1'b1; i_addr = 64'h8000_0008;
    sb.push_back('{1'b0, 64'h1111_2222_3333_4444});
    serve(64'h8000_0008, 1'b0, 64'd0, 8'h00, 0, 2, 64'h1111_2222_3333_4444, 1'b0);
    wait_valid(1'b0);
    i_ena = 1'b0;

    // d-cache write; bridge rdata is junk and must not reach d_data
    @(negedge clk);
    d_ena = 1'b1; d_we = 1'b1; d_addr = 64'h8000_1000;
    d_wdata = 64'hDEAD_BEEF_0000_0001; d_wstrb = 8'h0F;
    sb.push_back('{1'b1, 64'd0});
    serve(64'h8000_1000, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h0F, 0, 1,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_valid(1'b1);
    d_ena = 1'b0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;

    // m_done together with m_ack: valid next cycle, exactly one cycle wide
    @(negedge clk);
    i_ena = 1'b1; i_addr = 64'h8000_0010;
    sb.push_back('{1'b0, 64'hA5A5_5A5A_0123_4567});
    serve(64'h8000_0010, 1'b0, 64'd0, 8'h00, 0, 1, 64'hA5A5_5A5A_0123_4567, 1'b1);
    chk("same_cycle_valid", {63'b0, i_valid}, 64'd1);
    i_ena = 1'b0;
    @(negedge clk);
    chk("valid_width", {63'b0, i_valid}, 64'd0);

    // back-pressure: i granted first, d arrives later and must wait
    @(negedge clk);
    i_ena = 1'b1; i_addr = 64'h8000_0020;
    @(negedge clk);
    d_ena = 1'b1; d_we = 1'b0; d_addr = 64'h8000_2000;
    sb.push_back('{1'b0, 64'h0000_0000_CAFE_0001});
    serve(64'h8000_0020, 1'b0, 64'd0, 8'h00, 5, 1, 64'h0000_0000_CAFE_0001, 1'b0);
    wait_valid(1'b0);
    i_ena = 1'b0;
    sb.push_back('{1'b1, 64'h0000_0000_CAFE_0002});
    serve(64'h8000_2000, 1'b0, 64'd0, 8'h00, 0, 1, 64'h0000_0000_CAFE_0002, 1'b0);
    wait_valid(1'b1);
    d_ena = 1'b0;

    // both masters held for three transactions
`ifdef YSYX_22051013_ARB_RR_EN
    order = 3'b010;
`else
    order = 3'b111;
`endif
    @(negedge clk);
    i_ena = 1'b1; i_addr = 64'h8000_3000;
    d_ena = 1'b1; d_we = 1'b0; d_addr = 64'h8000_4000;
    for (int t = 0; t < 3; t++) begin
      own = order[t];
      rd  = 64'h7700_0000_0000_0000 | 64'(t);
      sb.push_back('{own, rd});
      serve(own ? 64'h8000_4000 : 64'h8000_3000, 1'b0, 64'd0, 8'h00, 0, 1, rd, 1'b0);
      wait_valid(own);
    end
    i_ena = 1'b0; d_ena = 1'b0;

    // m_done while idle is ignored
    @(negedge clk);
    @(negedge clk);
    m_done = 1'b1; m_rdata = 64'h1234;
    @(negedge clk);
    m_done = 1'b0;
    repeat (3) @(negedge clk);

    // reset during WAIT aborts at once
    i_ena = 1'b1; i_addr = 64'h8000_5000;
    wait_req();
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_zero();
    i_ena = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero();
    i_ena = 1'b1; i_addr = 64'h8000_6000;
    sb.push_back('{1'b0, 64'h0BAD_F00D_0000_0006});
    serve(64'h8000_6000, 1'b0, 64'd0, 8'h00, 0, 1, 64'h0BAD_F00D_0000_0006, 1'b0);
    wait_valid(1'b0);
    i_ena = 1'b0;

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
